// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
//   state_e : arbiter FSM states
//   owner_e : which requester holds the current access
//   DEF_*   : default timing parameters
//   cnt_width / streak_width : register widths for the access and streak counters
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    typedef enum logic {
        OWN_D = 1'b0,
        OWN_I = 1'b1
    } owner_e;

    localparam int DEF_ACCESS_CYCLES = 2;
    localparam int DEF_STARVE_LIMIT  = 3;

    // The access counter holds ACCESS_CYCLES-1 down to 0. Keep at least one bit
    // so ACCESS_CYCLES=1 still gives a legal register.
    function automatic int cnt_width(input int access_cycles);
        return (access_cycles > 1) ? $clog2(access_cycles) : 1;
    endfunction

    // The streak counter must be able to hold the value STARVE_LIMIT itself.
    function automatic int streak_width(input int starve_limit);
        return (starve_limit > 0) ? $clog2(starve_limit + 1) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester and memory-side signals around the arbiter.
//   master modport : requesters + memory model (drive requests, mem_readdata)
//   slave modport  : the arbiter (drives acks, read data, memory strobes, busy)
// Data port  : d_req, d_we, d_addr, d_wdata -> d_ack, d_rdata
// Fetch port : i_req, i_addr                -> i_ack, i_rdata
// Memory     : mem_addr, mem_writedata, MemWrite, MemRead <- mem_readdata
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ack;
    logic [DW-1:0] d_rdata;

    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_ack;
    logic [DW-1:0] i_rdata;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_writedata;
    logic          MemWrite;
    logic          MemRead;
    logic [DW-1:0] mem_readdata;

    logic          busy;

    modport master (
        output d_req, d_we, d_addr, d_wdata, i_req, i_addr, mem_readdata,
        input  d_ack, d_rdata, i_ack, i_rdata,
               mem_addr, mem_writedata, MemWrite, MemRead, busy
    );

    modport slave (
        input  d_req, d_we, d_addr, d_wdata, i_req, i_addr, mem_readdata,
        output d_ack, d_rdata, i_ack, i_rdata,
               mem_addr, mem_writedata, MemWrite, MemRead, busy
    );
endinterface

// File: rtl/mem_arb_pick.sv
// Winner selection and anti-starvation streak counter.
//   clk, rst : clock, async active-high reset
//   grant_en : arbiter is in IDLE, so a request present now is granted
//   d_req    : data-port request
//   i_req    : fetch request
//   d_wins   : data port wins this grant (only meaningful when a request is present)
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic clk,
    input  logic rst,
    input  logic grant_en,
    input  logic d_req,
    input  logic i_req,
    output logic d_wins
);

    localparam int SW = streak_width(STARVE_LIMIT);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    logic [SW-1:0] streak_q, streak_d;

    always_comb begin
        d_wins   = d_req && !(i_req && (streak_q == LIMIT));
        streak_d = streak_q;
        if (grant_en && (d_req || i_req)) begin
            // Only data grants that actually made fetch wait count toward the streak.
            if (d_wins && i_req) begin
                streak_d = (streak_q == LIMIT) ? streak_q : streak_q + SW'(1);
            end else begin
                streak_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares a single-ported data memory between the data port and instruction
// fetch. Each access holds the strobes for ACCESS_CYCLES cycles, then pulses a
// one-cycle ack to the owner. Data has fixed priority, bounded by a streak
// counter so fetch cannot starve.
//   clk, rst : clock, async active-high reset
//   bus      : mem_arbiter_if slave modport (requesters + memory side)
//
// state  | meaning
// IDLE   | no access in flight; requests are sampled and a winner latched
// ACCESS | strobes driven from latched copy; cnt counts down to 0
// DONE   | strobes low; owner's ack high for this single cycle
//
// All outputs are registered: their next values are derived from the next
// FSM state, so they line up with the state they belong to.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ACCESS_CYCLES = DEF_ACCESS_CYCLES,
    parameter int STARVE_LIMIT  = DEF_STARVE_LIMIT,
    parameter int AW            = 32,
    parameter int DW            = 32
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    localparam int CW = cnt_width(ACCESS_CYCLES);
    localparam logic [CW-1:0] CNT_INIT = CW'(ACCESS_CYCLES - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    owner_e        owner_q, owner_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          we_q, we_d;

    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_writedata_q, mem_writedata_d;
    logic          mem_write_q, mem_write_d;
    logic          mem_read_q, mem_read_d;
    logic          d_ack_q, d_ack_d;
    logic          i_ack_q, i_ack_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic          busy_q, busy_d;

    logic grant_en;
    logic d_wins;

    assign grant_en = (state_q == IDLE);

    mem_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_pick (
        .clk      (clk),
        .rst      (rst),
        .grant_en (grant_en),
        .d_req    (bus.d_req),
        .i_req    (bus.i_req),
        .d_wins   (d_wins)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        d_rdata_d = d_rdata_q;
        i_rdata_d = i_rdata_q;

        case (state_q)
            IDLE: begin
                if (bus.d_req || bus.i_req) begin
                    state_d = ACCESS;
                    cnt_d   = CNT_INIT;
                    if (d_wins) begin
                        owner_d = OWN_D;
                        addr_d  = bus.d_addr;
                        wdata_d = bus.d_wdata;
                        we_d    = bus.d_we;
                    end else begin
                        owner_d = OWN_I;
                        addr_d  = bus.i_addr;
                        wdata_d = '0;
                        we_d    = 1'b0;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    // Memory read data is combinational off the registered address.
                    if (!we_q) begin
                        if (owner_q == OWN_D) begin
                            d_rdata_d = bus.mem_readdata;
                        end else begin
                            i_rdata_d = bus.mem_readdata;
                        end
                    end
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        mem_addr_d      = addr_d;
        mem_writedata_d = wdata_d;
        mem_read_d      = (state_d == ACCESS) && !we_d;
        // Single write strobe, on the final access cycle only.
        mem_write_d     = (state_d == ACCESS) && we_d && (cnt_d == '0);
        d_ack_d         = (state_d == DONE) && (owner_d == OWN_D);
        i_ack_d         = (state_d == DONE) && (owner_d == OWN_I);
        busy_d          = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            owner_q         <= OWN_D;
            addr_q          <= '0;
            wdata_q         <= '0;
            we_q            <= 1'b0;
            mem_addr_q      <= '0;
            mem_writedata_q <= '0;
            mem_write_q     <= 1'b0;
            mem_read_q      <= 1'b0;
            d_ack_q         <= 1'b0;
            i_ack_q         <= 1'b0;
            d_rdata_q       <= '0;
            i_rdata_q       <= '0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            owner_q         <= owner_d;
            addr_q          <= addr_d;
            wdata_q         <= wdata_d;
            we_q            <= we_d;
            mem_addr_q      <= mem_addr_d;
            mem_writedata_q <= mem_writedata_d;
            mem_write_q     <= mem_write_d;
            mem_read_q      <= mem_read_d;
            d_ack_q         <= d_ack_d;
            i_ack_q         <= i_ack_d;
            d_rdata_q       <= d_rdata_d;
            i_rdata_q       <= i_rdata_d;
            busy_q          <= busy_d;
        end
    end

    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_writedata = mem_writedata_q;
    assign bus.MemWrite      = mem_write_q;
    assign bus.MemRead       = mem_read_q;
    assign bus.d_ack         = d_ack_q;
    assign bus.i_ack         = i_ack_q;
    assign bus.d_rdata       = d_rdata_q;
    assign bus.i_rdata       = i_rdata_q;
    assign bus.busy          = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(32), .DW(32)) bus();

    mem_arbiter #(
        .ACCESS_CYCLES (2),
        .STARVE_LIMIT  (3),
        .AW            (32),
        .DW            (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Word-addressed memory model, combinational read, write on clock edge.
    logic [31:0] mem [0:15];
    always_comb bus.mem_readdata = mem[bus.mem_addr[5:2]];
    always @(posedge clk) if (bus.MemWrite) mem[bus.mem_addr[5:2]] <= bus.mem_writedata;

    int checks   = 0;
    int failures = 0;

    task automatic run_d(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         output int ack_at, output int rd_cnt, output int wr_cnt,
                         output int wr_at, output int iack_cnt, output logic [31:0] rdata);
        ack_at = 0; rd_cnt = 0; wr_cnt = 0; wr_at = 0; iack_cnt = 0; rdata = '0;
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (bus.MemRead)  rd_cnt++;
            if (bus.MemWrite) begin wr_cnt++; wr_at = k; end
            if (bus.i_ack)    iack_cnt++;
            if (bus.d_ack) begin ack_at = k; rdata = bus.d_rdata; break; end
        end
        bus.d_req = 1'b0; bus.d_we = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_i(input logic [31:0] addr,
                         output int ack_at, output int rd_cnt, output int wr_cnt,
                         output int dack_cnt, output logic [31:0] rdata);
        ack_at = 0; rd_cnt = 0; wr_cnt = 0; dack_cnt = 0; rdata = '0;
        @(negedge clk);
        bus.i_req = 1'b1; bus.i_addr = addr;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (bus.MemRead)  rd_cnt++;
            if (bus.MemWrite) wr_cnt++;
            if (bus.d_ack)    dack_cnt++;
            if (bus.i_ack) begin ack_at = k; rdata = bus.i_rdata; break; end
        end
        bus.i_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.mem_addr !== 32'd0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0", bus.mem_addr); end
        checks++; if (bus.mem_writedata !== 32'd0) begin failures++; $display("FAIL reset_mem_writedata got=%h exp=0", bus.mem_writedata); end
        checks++; if (bus.MemWrite !== 1'b0) begin failures++; $display("FAIL reset_MemWrite got=%b exp=0", bus.MemWrite); end
        checks++; if (bus.MemRead !== 1'b0) begin failures++; $display("FAIL reset_MemRead got=%b exp=0", bus.MemRead); end
        checks++; if (bus.d_ack !== 1'b0 || bus.i_ack !== 1'b0) begin failures++; $display("FAIL reset_acks got=%b%b exp=00", bus.d_ack, bus.i_ack); end
        checks++; if (bus.d_rdata !== 32'd0 || bus.i_rdata !== 32'd0) begin failures++; $display("FAIL reset_rdata got=%h/%h exp=0/0", bus.d_rdata, bus.i_rdata); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    endtask

    task automatic test_data_read();
        int ack_at, rd_cnt, wr_cnt, wr_at, iack_cnt;
        logic [31:0] rdata;
        run_d(1'b0, 32'd40, 32'd0, ack_at, rd_cnt, wr_cnt, wr_at, iack_cnt, rdata);
        checks++; if (ack_at !== 3) begin failures++; $display("FAIL read_ack_cycle got=%0d exp=3", ack_at); end
        checks++; if (rd_cnt !== 2) begin failures++; $display("FAIL read_memread_cycles got=%0d exp=2", rd_cnt); end
        checks++; if (wr_cnt !== 0) begin failures++; $display("FAIL read_memwrite_cycles got=%0d exp=0", wr_cnt); end
        checks++; if (iack_cnt !== 0) begin failures++; $display("FAIL read_i_ack got=%0d exp=0", iack_cnt); end
        checks++; if (rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL read_d_rdata got=%h exp=deadbeef", rdata); end
        checks++; if (bus.d_ack !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL read_after_done ack=%b busy=%b exp=0/0", bus.d_ack, bus.busy); end
        checks++; if (bus.d_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL read_d_rdata_hold got=%h exp=deadbeef", bus.d_rdata); end
    endtask

    task automatic test_data_write();
        int ack_at, rd_cnt, wr_cnt, wr_at, iack_cnt;
        logic [31:0] rdata;
        run_d(1'b1, 32'd20, 32'd50, ack_at, rd_cnt, wr_cnt, wr_at, iack_cnt, rdata);
        checks++; if (ack_at !== 3) begin failures++; $display("FAIL write_ack_cycle got=%0d exp=3", ack_at); end
        checks++; if (wr_cnt !== 1) begin failures++; $display("FAIL write_memwrite_cycles got=%0d exp=1", wr_cnt); end
        checks++; if (wr_at !== 2) begin failures++; $display("FAIL write_memwrite_pos got=%0d exp=2", wr_at); end
        checks++; if (rd_cnt !== 0) begin failures++; $display("FAIL write_memread_cycles got=%0d exp=0", rd_cnt); end
        checks++; if (bus.d_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL write_d_rdata_unchanged got=%h exp=deadbeef", bus.d_rdata); end
        run_d(1'b0, 32'd20, 32'd0, ack_at, rd_cnt, wr_cnt, wr_at, iack_cnt, rdata);
        checks++; if (rdata !== 32'd50) begin failures++; $display("FAIL write_readback got=%0d exp=50", rdata); end
    endtask

    task automatic test_contention();
        logic [7:0] seq = '0;
        int n = 0;
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'd40;
        bus.i_req = 1'b1; bus.i_addr = 32'd4;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (bus.d_ack && bus.i_ack) begin
                checks++; failures++; $display("FAIL contention_dual_ack got=11 exp=one-hot");
            end
            if (bus.d_ack) begin
                seq = {seq[6:0], 1'b0}; n++;
                checks++; if (bus.d_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL contention_d_rdata got=%h exp=deadbeef", bus.d_rdata); end
            end
            if (bus.i_ack) begin
                seq = {seq[6:0], 1'b1}; n++;
                checks++; if (bus.i_rdata !== 32'd77) begin failures++; $display("FAIL contention_i_rdata got=%0d exp=77", bus.i_rdata); end
            end
            if (n == 8) break;
        end
        bus.d_req = 1'b0; bus.i_req = 1'b0;
        @(negedge clk);
        checks++; if (n !== 8) begin failures++; $display("FAIL contention_ack_count got=%0d exp=8", n); end
        checks++; if (seq !== 8'h11) begin failures++; $display("FAIL contention_order got=%b exp=00010001 (1=I)", seq); end
    endtask

    task automatic test_fetch_only();
        int ack_at, rd_cnt, wr_cnt, dack_cnt;
        logic [31:0] rdata;
        run_i(32'd0, ack_at, rd_cnt, wr_cnt, dack_cnt, rdata);
        checks++; if (ack_at !== 3) begin failures++; $display("FAIL fetch_ack_cycle got=%0d exp=3", ack_at); end
        checks++; if (rd_cnt !== 2) begin failures++; $display("FAIL fetch_memread_cycles got=%0d exp=2", rd_cnt); end
        checks++; if (wr_cnt !== 0) begin failures++; $display("FAIL fetch_memwrite got=%0d exp=0", wr_cnt); end
        checks++; if (dack_cnt !== 0) begin failures++; $display("FAIL fetch_d_ack got=%0d exp=0", dack_cnt); end
        checks++; if (rdata !== 32'h0A0B0C0D) begin failures++; $display("FAIL fetch_i_rdata got=%h exp=0a0b0c0d", rdata); end
        checks++; if (dut.u_pick.streak_q !== 2'd0) begin failures++; $display("FAIL fetch_streak got=%0d exp=0", dut.u_pick.streak_q); end
    endtask

    task automatic test_reset_mid_write();
        int ack_at, rd_cnt, wr_cnt, wr_at, iack_cnt;
        logic [31:0] rdata;
        int wr_seen = 0;
        int ack_seen = 0;
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'd8; bus.d_wdata = 32'd333;
        @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL midwr_in_access busy=%b exp=1", bus.busy); end
        if (bus.MemWrite) wr_seen++;
        rst = 1'b1;
        #1;
        checks++; if (bus.busy !== 1'b0 || bus.MemRead !== 1'b0 || bus.MemWrite !== 1'b0) begin
            failures++; $display("FAIL midwr_async_drop busy=%b rd=%b wr=%b exp=000", bus.busy, bus.MemRead, bus.MemWrite);
        end
        bus.d_req = 1'b0; bus.d_we = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 1) rst = 1'b0;
            if (bus.MemWrite) wr_seen++;
            if (bus.d_ack) ack_seen++;
        end
        checks++; if (wr_seen !== 0) begin failures++; $display("FAIL midwr_memwrite got=%0d exp=0", wr_seen); end
        checks++; if (ack_seen !== 0) begin failures++; $display("FAIL midwr_d_ack got=%0d exp=0", ack_seen); end
        run_d(1'b0, 32'd8, 32'd0, ack_at, rd_cnt, wr_cnt, wr_at, iack_cnt, rdata);
        checks++; if (rdata !== 32'h00001234) begin failures++; $display("FAIL midwr_readback got=%h exp=00001234", rdata); end
    endtask

    initial begin
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.i_req = 1'b0; bus.i_addr = '0;
        for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
        mem[0]  <= 32'h0A0B0C0D;
        mem[1]  <= 32'd77;
        mem[2]  <= 32'h00001234;
        mem[10] <= 32'hDEADBEEF;
        test_reset();
        test_data_read();
        test_data_write();
        test_contention();
        test_fetch_only();
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-ported data_memory between two requesters: the data port (lw/sw from the MEM stage) and the instruction-fetch port.
- Sequences each access over a fixed multi-cycle window, then returns read data with a one-cycle ack to the winning requester.
- Data port has fixed priority. A streak counter stops the data port from starving instruction fetch.

Parameters:
- ACCESS_CYCLES, 2, cycles the memory strobes are held per access (>=1)
- STARVE_LIMIT, 3, consecutive data grants with fetch pending before fetch is forced to win
- AW, 32, address width
- DW, 32, data width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- d_req  in  1  data-port request; held until d_ack
- d_we  in  1  data-port write (1) / read (0)
- d_addr  in  AW  data-port byte address
- d_wdata  in  DW  data-port write data
- d_ack  out  1  one-cycle completion pulse to data port
- d_rdata  out  DW  data-port read result, valid from d_ack onward
- i_req  in  1  fetch request; held until i_ack
- i_addr  in  AW  fetch address
- i_ack  out  1  one-cycle completion pulse to fetch port
- i_rdata  out  DW  fetched word, valid from i_ack onward
- mem_addr  out  AW  to data_memory addr
- mem_writedata  out  DW  to data_memory writedata
- MemWrite  out  1  to data_memory write strobe
- MemRead  out  1  to data_memory read strobe
- mem_readdata  in  DW  from data_memory readdata (combinational)
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst=1): state=IDLE, streak=0, all outputs 0 (mem_addr, mem_writedata, MemWrite, MemRead, d_ack, i_ack, d_rdata, i_rdata, busy).
- FSM states are IDLE, ACCESS and DONE; all outputs are registered.
- IDLE:
  - No request: stay in IDLE.
  - Otherwise pick a winner. Data wins if d_req=1 and not (i_req=1 and streak==STARVE_LIMIT); else fetch wins.
  - Latch owner, addr, wdata and we (fetch is always we=0). Load cnt=ACCESS_CYCLES-1 and go to ACCESS.
- ACCESS:
  - mem_addr and mem_writedata carry the latched values; MemRead=!we for every ACCESS cycle.
  - MemWrite=we only on the cycle with cnt==0, so exactly one write strobe per access.
  - At cnt==0: if !we, capture mem_readdata into the owner's rdata register; go to DONE. Otherwise cnt decrements.
- DONE:
  - Strobes 0; owner's ack=1 for exactly this cycle; next state is IDLE.
  - The requester drops or changes req on the edge that ends DONE.
- Latency: request sampled in IDLE at cycle t -> ack during cycle t+ACCESS_CYCLES+1.
- Issue rate: one access per ACCESS_CYCLES+2 cycles maximum.
- Streak counter (saturating, width clog2(STARVE_LIMIT+1)):
  - Data grant while i_req=1: streak++.
  - Fetch grant, or data grant with i_req=0: streak=0.
- Requests are sampled only in IDLE. Req/addr/data changes during ACCESS/DONE are ignored (latched copy used).
- d_rdata and i_rdata hold their last value until the next read for that port. A write does not alter d_rdata.
- Simultaneous d_req and i_req with streak<STARVE_LIMIT: data wins; fetch waits with no ack.
- Reset mid-ACCESS: strobes drop immediately (async). A write whose cnt==0 cycle has not occurred is not performed, and no ack is issued.
- Addresses pass through unchanged; alignment is the memory's concern.

Decomposition:
- Package mem_arb_pkg:
  - state enum (IDLE, ACCESS, DONE)
  - owner encoding (OWN_D=0, OWN_I=1)
  - default ACCESS_CYCLES and STARVE_LIMIT constants
- Sub-module mem_arb_pick (combinational winner selection plus streak-counter register). This is natural and keeps the FSM in mem_arbiter readable.

Test Plan:
- Reset: memory preloaded with word 0xDEADBEEF at addr 40; rst pulse 1->0 -> all outputs 0, busy=0.
- Data read: d_req=1, d_we=0, d_addr=40 with ACCESS_CYCLES=2 -> MemRead=1 for 2 cycles, then d_ack pulses once 3 cycles after sampling, with d_rdata=0xDEADBEEF; i_ack stays 0.
- Data write: d_we=1, d_addr=20, d_wdata=50 -> MemWrite high exactly 1 cycle (second ACCESS cycle), then d_ack. A following read of addr 20 returns 50; d_rdata unchanged between.
- Contention: d_req and i_req both held, i_addr=4 (word 77 preloaded), STARVE_LIMIT=3, data reads re-requested on each ack -> grant order D,D,D,I,D,D,D,I; i_rdata=77 on the i_ack.
- Fetch only: i_req=1, i_addr=0, d_req=0 -> i_ack after 3 cycles, streak stays 0, mem_writedata never strobed (MemWrite=0 throughout).
- Reset mid-write: d_we=1, d_addr=8, d_wdata=333, rst asserted during first ACCESS cycle -> MemWrite never pulses, no d_ack; readback of addr 8 after reset shows the old contents.
